ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter; the send side of the keyboard link (sets LEDs, resets, enables scanning).
//  Accepts one command byte from the CPU memory map and performs the full PS/2 host request-to-send sequence:
//   inhibit, start, 8 data bits, odd parity, stop, device ACK.
//  Drives open-drain PS2_CLK/PS2_DAT through active-high pull-low enables.
//  Raises tx_busy so the keyboard receiver ignores bus traffic while a transfer is in progress.
// PARAMETERS
//  INHIBIT_CYC  5000    clk cycles PS2_CLK is held low before start (100 us at 50 MHz)
//  TIMEOUT_CYC  750000  max cycles from clock release to end of ACK (15 ms); exceeding it is an error
//  MAX_RETRY    2       extra attempts after NACK/timeout; used only with PS2_TX_RETRY_EN
// PORTS
//  clk          in   1  system clock (CLOCK_50)
//  rst_n        in   1  synchronous reset, active low
//  tx_valid     in   1  command byte present on tx_data
//  tx_data      in   8  command byte (e.g. 8'hED set LEDs, 8'hFF reset)
//  tx_ready     out  1  high when idle; byte accepted on the cycle tx_valid && tx_ready
//  tx_busy      out  1  transfer in progress (INHIBIT..WAIT_IDLE)
//  tx_done      out  1  one-cycle pulse: ACK received, bus idle again
//  tx_err       out  1  one-cycle pulse: NACK or timeout (after retries are exhausted)
//  ps2_clk_i    in   1  PS2_CLK pad level (asynchronous)
//  ps2_dat_i    in   1  PS2_DAT pad level (asynchronous)
//  ps2_clk_oe   out  1  1 = pull PS2_CLK low, 0 = release (tristate)
//  ps2_dat_oe   out  1  1 = pull PS2_DAT low, 0 = release
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): state=IDLE; tx_ready=1; tx_busy=0; tx_done=0; tx_err=0; ps2_clk_oe=0; ps2_dat_oe=0.
//   A reset mid-transfer releases both lines on the next edge; no done/err pulse is produced.
//  Pad inputs: 2-FF synchronized. fall = synced clk was 1 last cycle and is 0 now. All bus decisions use synced values.
//  Accept: on tx_valid && tx_ready, latch shift reg {parity, data} with parity = ~^tx_data (odd parity).
//   Same cycle: go to INHIBIT, tx_ready drops to 0. tx_valid while busy is ignored.
//  INHIBIT: clk_oe=1 for INHIBIT_CYC cycles. On the last of those cycles, dat_oe=1.
//  START: clk_oe=0 with dat_oe held 1. Clear the bit counter and the timeout counter.
//  Falling edges drive data:
//   - falls 1..8: dat_oe = ~data[n-1], LSB first.
//   - fall 9: dat_oe = ~parity.
//   - fall 10: dat_oe=0 (stop bit, line released).
//  ACK: at fall 11, sample synced dat. dat==0 means ACK; dat==1 means NACK.
//  WAIT_IDLE: after ACK, wait for synced clk==1 && dat==1, then pulse tx_done and return to IDLE (tx_ready=1).
//  NACK: treated as an error.
//  Timeout: the counter runs from START to the end of WAIT_IDLE. Reaching TIMEOUT_CYC triggers abort:
//   - release both lines;
//   - pulse tx_err;
//   - return to IDLE.
//  tx_done and tx_err are never both asserted. tx_busy = !tx_ready.
//  Latency: byte accepted -> clk released = INHIBIT_CYC+1 cycles. The remainder is paced by the device (10-16.7 kHz).
// CONFIGURATION
//  `define PS2_TX_RETRY_EN
//   With it: on NACK or timeout, if retries < MAX_RETRY, restart at INHIBIT with the latched byte.
//    tx_err pulses only after the final failed attempt. The retry counter clears on accept.
//   Without it: the first NACK or timeout pulses tx_err immediately. MAX_RETRY is unused.
// STRUCTURE
//  Shared header ps2_defs.vh holds:
//   - state encodings (IDLE, INHIBIT, START, DATA, PARITY, STOP, ACK, WAIT_IDLE);
//   - command constants PS2_CMD_SET_LED=8'hED, PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4.
//  Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge detector, one instance per line.
//   Reusable by the keyboard receiver.
// TESTING
//  Device BFM: clocks at 12.5 kHz, samples dat on rising clk, drives ACK low during clock 11.
//  1. send 8'hED -> clk held low exactly 5000 cycles; BFM receives bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//     tx_done pulses once.
//  2. send 8'h01 -> BFM sees parity 0; tx_done pulses; tx_ready returns to 1.
//  3. BFM leaves dat high at clock 11 (NACK), macro off -> tx_err pulses once, both oe=0, tx_done never asserts.
//  4. BFM never clocks, TIMEOUT_CYC=20000 -> tx_err pulses 20000 cycles after clock release; lines released.
//  5. rst_n low during bit 4 -> next cycle both oe=0, tx_ready=1; a new 8'hF4 then completes normally.
//  6. PS2_TX_RETRY_EN, BFM NACKs twice then ACKs -> three inhibit phases, no tx_err, one tx_done;
//     a second tx_valid during the transfer is ignored.

Source files
------------

// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter.
// Holds the FSM state encodings, the common keyboard command bytes,
// the latched frame payload type and the odd-parity helper.
package ps2_host_tx_pkg;

    localparam int unsigned STATE_W = 3;

    // Transmitter states
    localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] ST_INHIBIT   = 3'd1;
    localparam logic [STATE_W-1:0] ST_START     = 3'd2;
    localparam logic [STATE_W-1:0] ST_DATA      = 3'd3;
    localparam logic [STATE_W-1:0] ST_PARITY    = 3'd4;
    localparam logic [STATE_W-1:0] ST_STOP      = 3'd5;
    localparam logic [STATE_W-1:0] ST_ACK       = 3'd6;
    localparam logic [STATE_W-1:0] ST_WAIT_IDLE = 3'd7;

    // Common keyboard commands
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

    // Latched command byte plus its parity bit
    typedef struct packed {
        logic       parity;
        logic [7:0] data;
    } frame_t;

    // PS/2 uses odd parity: parity bit makes the total count of ones odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer with falling-edge detect for one PS/2 pad.
// Ports:
//   clk, rst_n : system clock, synchronous active-low reset
//   pad        : raw asynchronous pad level
//   level      : synchronized level (idle/reset value 1)
//   fall       : one-cycle pulse on the cycle level goes 1 -> 0
module ps2_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    output logic level,
    output logic fall
);

    logic meta;

    // fall is computed from the same inputs that load level, so it is
    // high exactly on the cycle level becomes 0 after having been 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta  <= 1'b1;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            meta  <= pad;
            level <= meta;
            fall  <= level & ~meta;
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits
// LSB first, odd parity, stop, device ACK, then wait for an idle bus.
// Optional macro PS2_TX_RETRY_EN: retry up to MAX_RETRY times after a
// NACK or timeout before reporting tx_err.
// Ports:
//   clk, rst_n            : system clock, synchronous active-low reset
//   tx_valid, tx_data     : command byte offer from the CPU
//   tx_ready              : idle, byte accepted on tx_valid && tx_ready
//   tx_busy               : transfer in progress (always !tx_ready)
//   tx_done, tx_err       : one-cycle completion / failure pulses
//   ps2_clk_i, ps2_dat_i  : asynchronous pad levels
//   ps2_clk_oe, ps2_dat_oe: 1 = pull the line low, 0 = release
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 750000,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);

    localparam int unsigned INH_W   = $clog2(INHIBIT_CYC);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_CYC);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 2);

    logic               clk_lvl, clk_fall;
    logic               dat_lvl, dat_fall_unused;

    logic [STATE_W-1:0] state, state_nxt;
    logic [INH_W-1:0]   inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt;
    logic [2:0]         bit_cnt, bit_cnt_nxt;
    frame_t             frame, frame_nxt;
    logic [RETRY_W-1:0] retry_cnt, retry_nxt;
    logic               clk_oe_nxt, dat_oe_nxt;
    logic               ready_nxt, done_nxt, err_nxt;
    logic               fail, bus_phase, can_retry;

    ps2_line_sync u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (ps2_clk_i),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    // Data-line edges carry no meaning for the sender
    ps2_line_sync u_dat_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (ps2_dat_i),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

`ifdef PS2_TX_RETRY_EN
    assign can_retry = (retry_cnt < RETRY_W'(MAX_RETRY));
`else
    assign can_retry = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        inh_cnt_nxt = inh_cnt;
        to_cnt_nxt  = to_cnt;
        bit_cnt_nxt = bit_cnt;
        frame_nxt   = frame;
        retry_nxt   = retry_cnt;
        clk_oe_nxt  = ps2_clk_oe;
        dat_oe_nxt  = ps2_dat_oe;
        ready_nxt   = tx_ready;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        fail        = 1'b0;

        // Timeout runs over the whole device-paced part of the transfer
        bus_phase = (state != ST_IDLE) && (state != ST_INHIBIT);
        if (bus_phase) begin
            if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                fail = 1'b1;
            end else begin
                to_cnt_nxt = to_cnt + TO_W'(1);
            end
        end

        case (state)
            ST_IDLE: begin
                ready_nxt  = 1'b1;
                clk_oe_nxt = 1'b0;
                dat_oe_nxt = 1'b0;
                if (tx_valid && tx_ready) begin
                    frame_nxt.data   = tx_data;
                    frame_nxt.parity = odd_parity(tx_data);
                    retry_nxt        = '0;
                    inh_cnt_nxt      = '0;
                    clk_oe_nxt       = 1'b1;
                    ready_nxt        = 1'b0;
                    state_nxt        = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                // Data goes low one cycle before clock release (request-to-send)
                if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                    clk_oe_nxt  = 1'b0;
                    to_cnt_nxt  = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = ST_START;
                end else begin
                    inh_cnt_nxt = inh_cnt + INH_W'(1);
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 2)) begin
                        dat_oe_nxt = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (clk_fall) begin
                    dat_oe_nxt = ~frame.data[bit_cnt];
                    if (bit_cnt == 3'd7) begin
                        state_nxt = ST_PARITY;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (clk_fall) begin
                    dat_oe_nxt = ~frame.parity;
                    state_nxt  = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clk_fall) begin
                    dat_oe_nxt = 1'b0;
                    state_nxt  = ST_ACK;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    if (!dat_lvl) begin
                        state_nxt = ST_WAIT_IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // NACK or timeout: release the bus, then retry or report
        if (fail) begin
            clk_oe_nxt = 1'b0;
            dat_oe_nxt = 1'b0;
            done_nxt   = 1'b0;
            if (can_retry) begin
                retry_nxt   = retry_cnt + RETRY_W'(1);
                inh_cnt_nxt = '0;
                clk_oe_nxt  = 1'b1;
                state_nxt   = ST_INHIBIT;
            end else begin
                err_nxt   = 1'b1;
                ready_nxt = 1'b1;
                state_nxt = ST_IDLE;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            inh_cnt    <= '0;
            to_cnt     <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            retry_cnt  <= '0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            tx_ready   <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state      <= state_nxt;
            inh_cnt    <= inh_cnt_nxt;
            to_cnt     <= to_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            frame      <= frame_nxt;
            retry_cnt  <= retry_nxt;
            ps2_clk_oe <= clk_oe_nxt;
            ps2_dat_oe <= dat_oe_nxt;
            tx_ready   <= ready_nxt;
            tx_busy    <= ~ready_nxt;
            tx_done    <= done_nxt;
            tx_err     <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with a PS/2 device model.
// Expected frames and outcomes are queued by the stimulus; the device
// model and an output monitor pop and compare them independently.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int unsigned INH  = 5000;
    localparam int unsigned TO   = 20000;
    localparam int unsigned HALF = 25;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, tx_busy, tx_done, tx_err;
    logic       clk_oe, dat_oe;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_pad, ps2_dat_pad;

    assign ps2_clk_pad = ~(clk_oe | dev_clk_low);
    assign ps2_dat_pad = ~(dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYC (INH),
        .TIMEOUT_CYC (TO),
        .MAX_RETRY   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .ps2_clk_i  (ps2_clk_pad),
        .ps2_dat_i  (ps2_dat_pad),
        .ps2_clk_oe (clk_oe),
        .ps2_dat_oe (dat_oe)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic is_err;
        int   lat;
    } outcome_t;

    outcome_t   out_q[$];
    logic [9:0] frame_q[$];

    // Device model controls
    int   nack_left   = 0;
    logic noclk       = 1'b0;
    logic check_en    = 1'b1;
    int   bfm_clk_num = 0;
    logic bfm_active  = 1'b0;

    // Monitor observations
    int   inh_run    = 0;
    int   inh_len    = 0;
    int   inh_phases = 0;
    int   t_release  = 0;
    logic prev_clk_oe = 1'b0;
    logic prev_dat_oe = 1'b0;

    // Output monitor
    initial begin : monitor
        outcome_t o;
        forever begin
            @(negedge clk);
            if (clk_oe === 1'b1) begin
                inh_run++;
            end else if (prev_clk_oe === 1'b1) begin
                inh_len = inh_run;
                inh_run = 0;
                inh_phases++;
                t_release = cyc;
                chk("dat_low_at_release", prev_dat_oe, 1);
            end
            if (tx_done === 1'b1 || tx_err === 1'b1) begin
                chk("done_err_exclusive", tx_done & tx_err, 0);
                chk("lines_released", {clk_oe, dat_oe}, 0);
                chk("ready_with_pulse", {tx_ready, tx_busy}, 2'b10);
                chk("outcome_expected", out_q.size() > 0, 1);
                if (out_q.size() > 0) begin
                    o = out_q.pop_front();
                    chk(o.is_err ? "tx_err_pulse" : "tx_done_pulse",
                        {tx_done, tx_err}, o.is_err ? 2'b01 : 2'b10);
                    if (o.lat >= 0) chk("timeout_latency", cyc - t_release, o.lat);
                end
            end
            prev_clk_oe = clk_oe;
            prev_dat_oe = dat_oe;
        end
    end

    // PS/2 device: waits for request-to-send, clocks 11 times, samples on rise
    initial begin : bfm
        logic [9:0] got;
        logic [9:0] exp_f;
        logic       do_ack;
        forever begin
            @(negedge clk);
            if (!noclk && ps2_clk_pad === 1'b1 && ps2_dat_pad === 1'b0) begin
                bfm_active = 1'b1;
                do_ack = (nack_left == 0);
                if (!do_ack) nack_left--;
                got = '0;
                repeat (HALF) @(negedge clk);
                for (int k = 1; k <= 11; k++) begin
                    dev_clk_low = 1'b1;
                    bfm_clk_num = k;
                    repeat (HALF) @(negedge clk);
                    dev_clk_low = 1'b0;
                    if (k <= 10) got = {ps2_dat_pad, got[9:1]};
                    if (k == 11) dev_dat_low = 1'b0;
                    if (k == 10 && do_ack) begin
                        repeat (HALF / 2) @(negedge clk);
                        dev_dat_low = 1'b1;
                        repeat (HALF - HALF / 2) @(negedge clk);
                    end else begin
                        repeat (HALF) @(negedge clk);
                    end
                end
                if (check_en) begin
                    chk("frame_expected", frame_q.size() > 0, 1);
                    if (frame_q.size() > 0) begin
                        exp_f = frame_q.pop_front();
                        chk("frame_bits", got, exp_f);
                    end
                end
                bfm_clk_num = 0;
                bfm_active  = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("accept_ready_drop", tx_ready, 0);
        chk("accept_busy", tx_busy, 1);
    endtask

    task automatic wait_quiet(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_q.size() == 0 && frame_q.size() == 0 && tx_ready === 1'b1 && !bfm_active)
                return;
        end
        chk({name, "_completion"},
            out_q.size() == 0 && frame_q.size() == 0 && tx_ready === 1'b1 && !bfm_active, 1);
    endtask

    task automatic push_out(input logic is_err, input int lat);
        outcome_t o;
        o.is_err = is_err;
        o.lat    = lat;
        out_q.push_back(o);
    endtask

    initial begin : watchdog
        repeat (120000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int ph0;
        int i;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_dat_oe", dat_oe, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Set-LED command: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
        frame_q.push_back(10'h3ED);
        push_out(1'b0, -1);
        send(8'hED);
        wait_quiet("t1", 20000);
        chk("t1_inhibit_len", inh_len, INH);
        chk("t1_ready_after", tx_ready, 1);

        // Single set bit: parity 0
        frame_q.push_back(10'h201);
        push_out(1'b0, -1);
        send(8'h01);
        wait_quiet("t2", 20000);
        chk("t2_ready_after", {tx_ready, tx_busy}, 2'b10);

`ifdef PS2_TX_RETRY_EN
        // Two NACKs then ACK: three inhibit phases, one done, stray offer ignored
        nack_left = 2;
        repeat (3) frame_q.push_back(10'h3FF);
        push_out(1'b0, -1);
        ph0 = inh_phases;
        send(8'hFF);
        repeat (200) @(negedge clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
        wait_quiet("t6", 40000);
        chk("t6_inhibit_phases", inh_phases - ph0, 3);
        chk("t6_nacks_used", nack_left, 0);

        // Silent device: the first timeout leads to a second attempt, not an error
        noclk = 1'b1;
        ph0 = inh_phases;
        send(8'h12);
        i = 0;
        while (inh_phases - ph0 < 2 && i < 35000) begin
            @(negedge clk);
            i++;
        end
        chk("t4_retry_after_timeout", inh_phases - ph0, 2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        noclk = 1'b0;
        @(negedge clk);
`else
        // NACK without retry: immediate tx_err, no tx_done
        nack_left = 1;
        frame_q.push_back(10'h355);
        push_out(1'b1, -1);
        send(8'h55);
        wait_quiet("t3", 20000);
        chk("t3_nack_used", nack_left, 0);

        // Silent device: tx_err exactly TO cycles after clock release
        noclk = 1'b1;
        push_out(1'b1, TO);
        send(8'hF4);
        wait_quiet("t4", 30000);
        chk("t4_lines_idle", {clk_oe, dat_oe}, 0);
        noclk = 1'b0;
`endif

        // Reset during bit 4 (8'h55 bit 3 = 0 so data is pulled low then)
        check_en = 1'b0;
        send(8'h55);
        i = 0;
        while (bfm_clk_num != 4 && i < 10000) begin
            @(negedge clk);
            i++;
        end
        chk("t5_reached_bit4", bfm_clk_num, 4);
        repeat (10) @(negedge clk);
        chk("t5_dat_driven", dat_oe, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_rst_lines", {clk_oe, dat_oe}, 0);
        chk("t5_rst_ready", {tx_ready, tx_busy}, 2'b10);
        rst_n = 1'b1;
        i = 0;
        while (bfm_active && i < 2000) begin
            @(negedge clk);
            i++;
        end
        chk("t5_device_idle", bfm_active, 0);
        check_en = 1'b1;
        repeat (5) @(negedge clk);

        // Enable-scanning after reset: parity 0
        frame_q.push_back(10'h2F4);
        push_out(1'b0, -1);
        send(8'hF4);
        wait_quiet("t5", 20000);
        chk("t5_ready_after", tx_ready, 1);

        repeat (20) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
